tdm_demux4: RTL and testbench

- Four-channel time-division demultiplexer; the receive-side counterpart of the 4:1 mux.
- Accepts a serial word stream, one word per valid cycle, framed as four slots (slot 0..3).
- Slot 0 is marked by frame_sync.
- Distributes the slots to four registered parallel outputs, updated atomically once per complete frame.
- Sits downstream of a mux-based serialiser and reconstructs IN0..IN3 from the serial stream.

---
 rtl/tdm_demux4.sv | 118 +++++++++++
 tb/tb_tdm_demux4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: rebuilds out0..out3 from a framed serial word stream.
// Optional TDM_DEMUX_FRAME_CNT_EN adds an 8-bit wrapping count of completed frames.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic [1:0]       slot
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_count
`endif
);

    typedef enum logic {HUNT, ACTIVE} state_t;

    state_t           state, state_d;
    logic [1:0]       slot_d;
    logic [WIDTH-1:0] shadow0, shadow1, shadow2;
    logic             load0, load_mid, complete, err;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state;
        slot_d   = slot;
        load0    = 1'b0;
        load_mid = 1'b0;
        complete = 1'b0;
        err      = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        state_d = ACTIVE;
                        slot_d  = 2'd1;
                        load0   = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (frame_sync) begin
                        // A sync anywhere but slot 0 aborts the partial frame and restarts it.
                        err    = (slot != 2'd0);
                        load0  = 1'b1;
                        slot_d = 2'd1;
                    end else begin
                        case (slot)
                            2'd0: begin
                                err     = 1'b1;
                                state_d = HUNT;
                                slot_d  = 2'd0;
                            end
                            2'd1, 2'd2: begin
                                load_mid = 1'b1;
                                slot_d   = slot + 2'd1;
                            end
                            2'd3: begin
                                complete = 1'b1;
                                slot_d   = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            slot        <= 2'd0;
            shadow0     <= '0;
            shadow1     <= '0;
            shadow2     <= '0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_d;
            slot        <= slot_d;
            frame_valid <= complete;
            sync_err    <= err;
            if (load0) shadow0 <= din;
            if (load_mid && slot == 2'd1) shadow1 <= din;
            if (load_mid && slot == 2'd2) shadow2 <= din;
            if (complete) begin
                out0 <= shadow0;
                out1 <= shadow1;
                out2 <= shadow2;
                out3 <= din;
            end
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)         frame_count <= 8'd0;
        else if (complete) frame_count <= frame_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: completed frames are queued when their last word
// is driven and popped when frame_valid appears.
module tb_tdm_demux4;

    localparam int W = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] out0, out1, out2, out3;
    logic         frame_valid, sync_err;
    logic [1:0]   slot;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [7:0]   frame_count;
`endif

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    int fv_base, se_base;
    logic [3:0] sb_q[$];
    logic [3:0] exp_frame;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .frame_valid(frame_valid),
        .sync_err   (sync_err),
        .slot       (slot)
`ifdef TDM_DEMUX_FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {out0[0], out1[0], out2[0], out3[0]};
    endfunction

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic fs, input logic d);
        @(negedge clk);
        din        = W'(d);
        din_valid  = v;
        frame_sync = fs;
        @(posedge clk);
        #1;
        if (frame_valid) begin
            fv_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_frame_valid", 32'(frame_valid), 32'd0);
            end else begin
                exp_frame = sb_q.pop_front();
                check("frame_outputs", 32'(outs()), 32'(exp_frame));
            end
        end
        if (sync_err) se_cnt++;
    endtask

    // Words are sent out0-first; f[3] is slot 0. Expected result queued with the last word.
    task automatic send_frame(input logic [3:0] f, input bit gaps);
        step(1'b1, 1'b1, f[3]);
        if (gaps) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, f[2]);
        if (gaps) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, f[1]);
        if (gaps) step(1'b0, 1'b0, 1'b0);
        sb_q.push_back(f);
        step(1'b1, 1'b0, f[0]);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset      = 1'b1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
        repeat (n) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;

        // Reset state
        do_reset(2);
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_se", 32'(sync_err), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);

        // Basic frame 1,0,1,0 with slot sequence 1,2,3,0
        fv_base = fv_cnt;
        step(1'b1, 1'b1, 1'b1); check("basic_slot1", 32'(slot), 32'd1);
        check("basic_no_fv_early", 32'(frame_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0); check("basic_slot2", 32'(slot), 32'd2);
        step(1'b1, 1'b0, 1'b1); check("basic_slot3", 32'(slot), 32'd3);
        check("basic_no_fv_slot3", 32'(frame_valid), 32'd0);
        sb_q.push_back(4'b1010);
        step(1'b1, 1'b0, 1'b0); check("basic_slot0", 32'(slot), 32'd0);
        check("basic_fv", 32'(frame_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0); check("basic_fv_pulse", 32'(frame_valid), 32'd0);
        check("basic_hold", 32'(outs()), 32'b1010);
        check("basic_fv_count", 32'(fv_cnt - fv_base), 32'd1);

        // Idle gaps, then back-to-back frame
        fv_base = fv_cnt;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0); check("gap_slot_hold", 32'(slot), 32'd1);
        check("gap_outs_hold", 32'(outs()), 32'b1010);
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0);
        sb_q.push_back(4'b1010);
        step(1'b1, 1'b0, 1'b0);
        send_frame(4'b0111, 1'b0);
        check("b2b_outs", 32'(outs()), 32'b0111);
        check("b2b_fv_count", 32'(fv_cnt - fv_base), 32'd2);

        // Early sync on slot 2 aborts partial frame
        fv_base = fv_cnt; se_base = se_cnt;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("early_se", 32'(sync_err), 32'd1);
        check("early_slot", 32'(slot), 32'd1);
        check("early_outs_kept", 32'(outs()), 32'b0111);
        step(1'b1, 1'b0, 1'b0);
        check("early_se_pulse", 32'(sync_err), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        sb_q.push_back(4'b0010);
        step(1'b1, 1'b0, 1'b0);
        check("early_outs", 32'(outs()), 32'b0010);
        check("early_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("early_se_count", 32'(se_cnt - se_base), 32'd1);

        // Lost sync: unsynced word in slot 0 drops to HUNT
        send_frame(4'b1111, 1'b0);
        se_base = se_cnt;
        step(1'b1, 1'b0, 1'b0);
        check("lost_se", 32'(sync_err), 32'd1);
        check("lost_slot", 32'(slot), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        check("hunt_no_err", 32'(sync_err), 32'd0);
        check("lost_outs_kept", 32'(outs()), 32'b1111);
        send_frame(4'b1100, 1'b0);
        check("lost_outs_new", 32'(outs()), 32'b1100);
        check("lost_se_count", 32'(se_cnt - se_base), 32'd1);

        // Reset mid-frame, then HUNT filtering of unsynced words
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        do_reset(1);
        check("midrst_outs", 32'(outs()), 32'd0);
        check("midrst_slot", 32'(slot), 32'd0);
        fv_base = fv_cnt; se_base = se_cnt;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check("hunt_slot", 32'(slot), 32'd0);
        send_frame(4'b0101, 1'b0);
        check("hunt_outs", 32'(outs()), 32'b0101);
        check("hunt_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        check("hunt_se_count", 32'(se_cnt - se_base), 32'd0);

`ifdef TDM_DEMUX_FRAME_CNT_EN
        check("cnt_after_one", 32'(frame_count), 32'd1);
        do_reset(1);
        check("cnt_rst", 32'(frame_count), 32'd0);
        for (int i = 0; i < 257; i++) send_frame(4'(i), 1'b0);
        check("cnt_wrap", 32'(frame_count), 32'd1);
        se_base = se_cnt;
        step(1'b1, 1'b0, 1'b0);
        check("cnt_err_unaffected", 32'(frame_count), 32'd1);
`endif

        step(1'b0, 1'b0, 1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
